// File: rtl/jtcontra_rom_arb_if.sv
// Bundle of the two tile-fetcher request ports and the shared SDRAM read port.
// slave = arbiter side, master = fetchers plus SDRAM side.
interface jtcontra_rom_arb_if #(
  parameter int AW = 18,
  parameter int DW = 16
);
  logic          req0_cs;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req0_ok;
  logic          req1_cs;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic          req1_ok;
  logic          rom_cs;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          rom_ok;

  modport slave (
    input  req0_cs, req0_addr, req1_cs, req1_addr, rom_data, rom_ok,
    output req0_data, req0_ok, req1_data, req1_ok, rom_cs, rom_addr
  );

  modport master (
    output req0_cs, req0_addr, req1_cs, req1_addr, rom_data, rom_ok,
    input  req0_data, req0_ok, req1_data, req1_ok, rom_cs, rom_addr
  );
endinterface

// File: rtl/jtcontra_rom_arb.sv
// Two-way round-robin arbiter sharing one SDRAM read port between the 007121
// tile fetchers, with a one-word cache slot per fetcher.
//   state | meaning
//   IDLE  | no transaction; pick a pending requester
//   ISSUE | rom_cs just raised; rom_ok is stale and ignored
//   WAIT  | waiting for rom_ok; capture into the granted slot
module jtcontra_rom_arb #(
  parameter int AW = 18,
  parameter int DW = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  jtcontra_rom_arb_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        r_state;
  logic [AW-1:0] r_addr0, r_addr1, r_rom_addr;
  logic [DW-1:0] r_data0, r_data1;
  logic          r_valid0, r_valid1, r_rom_cs;
  logic          r_gnt;
  logic          r_last;   // last requester served; reset to 1 so a tie goes to 0

  logic w_ok0, w_ok1, w_pend0, w_pend1, w_sel1;

  assign w_ok0   = bus.req0_cs & r_valid0 & (r_addr0 == bus.req0_addr);
  assign w_ok1   = bus.req1_cs & r_valid1 & (r_addr1 == bus.req1_addr);
  assign w_pend0 = bus.req0_cs & ~w_ok0;
  assign w_pend1 = bus.req1_cs & ~w_ok1;
  assign w_sel1  = w_pend1 & (~w_pend0 | ~r_last);

  assign bus.req0_ok   = w_ok0;
  assign bus.req1_ok   = w_ok1;
  assign bus.req0_data = r_data0;
  assign bus.req1_data = r_data1;
  assign bus.rom_cs    = r_rom_cs;
  assign bus.rom_addr  = r_rom_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_rom_cs   <= 1'b0;
      r_rom_addr <= '0;
      r_addr0    <= '0;
      r_addr1    <= '0;
      r_data0    <= '0;
      r_data1    <= '0;
      r_valid0   <= 1'b0;
      r_valid1   <= 1'b0;
      r_gnt      <= 1'b0;
      r_last     <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pend0 | w_pend1) begin
            r_state  <= ISSUE;
            r_rom_cs <= 1'b1;
            r_gnt    <= w_sel1;
            if (w_sel1) begin
              r_rom_addr <= bus.req1_addr;
              r_addr1    <= bus.req1_addr;
              r_valid1   <= 1'b0;
            end else begin
              r_rom_addr <= bus.req0_addr;
              r_addr0    <= bus.req0_addr;
              r_valid0   <= 1'b0;
            end
          end
        end
        ISSUE: r_state <= WAIT;
        WAIT: begin
          // Completion fills the slot with the issued address even if the
          // requester has since dropped cs or moved on.
          if (bus.rom_ok) begin
            r_state  <= IDLE;
            r_rom_cs <= 1'b0;
            r_last   <= r_gnt;
            if (r_gnt) begin
              r_data1  <= bus.rom_data;
              r_valid1 <= 1'b1;
            end else begin
              r_data0  <= bus.rom_data;
              r_valid0 <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jtcontra_rom_arb.sv
// Bench for jtcontra_rom_arb: SDRAM model with programmable latency and an
// optional always-high stale rom_ok, plus an in-order scoreboard of fetcher results.
module tb_jtcontra_rom_arb;
  localparam int AW = 18;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jtcontra_rom_arb_if #(.AW(AW), .DW(DW)) bus ();
  jtcontra_rom_arb #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    bit            id;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    bit            id;
    logic [AW-1:0] addr;
    int            dly;
    bit            stale;
    int            lat;
    int            nrom;
  } vec_t;

  exp_t          sb_q[$];
  logic [AW-1:0] iss_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            n_iss = 0;
  int            rom_dly = 1;
  bit            rom_stale = 1'b0;
  int            rom_cnt = 0;
  logic          p_ok0 = 1'b0, p_ok1 = 1'b0, p_cs = 1'b0;
  logic [AW-1:0] p_addr = '0;

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hBFCC ^ {a[17:16], 14'd0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic sb_push(input bit id, input logic [AW-1:0] a);
    exp_t e;
    e.id = id; e.addr = a; e.data = rom_fn(a);
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input bit id, input logic [DW-1:0] d);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL sb_unexpected: req%0d ok rose with data %0h, none expected", id, d);
    end else begin
      e = sb_q.pop_front();
      chk("sb_id", 32'(id), 32'(e.id));
      chk("sb_data", 32'(d), 32'(e.data));
    end
  endtask

  // SDRAM model: rom_ok rises rom_dly cycles after rom_cs (cycle 0 = ISSUE)
  initial begin
    bus.rom_ok = 1'b0;
    bus.rom_data = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.rom_cs) begin
        if (rom_cnt >= rom_dly) begin
          bus.rom_ok = 1'b1;
          bus.rom_data = rom_fn(bus.rom_addr);
        end else bus.rom_ok = rom_stale;
        rom_cnt++;
      end else begin
        rom_cnt = 0;
        bus.rom_ok = rom_stale;
      end
    end
  end

  always @(posedge bus.rom_cs) begin
    #1;
    n_iss++;
    iss_q.push_back(bus.rom_addr);
  end

  initial begin
    forever begin
      @(negedge clk); #1;
      if (bus.req0_ok && !p_ok0) sb_pop(1'b0, bus.req0_data);
      if (bus.req1_ok && !p_ok1) sb_pop(1'b1, bus.req1_data);
      if (bus.rom_cs && p_cs) chk("rom_addr_hold", 32'(bus.rom_addr), 32'(p_addr));
      p_ok0 = bus.req0_ok; p_ok1 = bus.req1_ok; p_cs = bus.rom_cs; p_addr = bus.rom_addr;
    end
  end

  task automatic do_req(input bit id, input logic [AW-1:0] a, input int lat, input int nrom,
                        input string nm);
    int n = 0;
    int i0 = n_iss;
    @(negedge clk);
    sb_push(id, a);
    if (id) begin bus.req1_cs = 1'b1; bus.req1_addr = a; end
    else    begin bus.req0_cs = 1'b1; bus.req0_addr = a; end
    #1;
    while (!(id ? bus.req1_ok : bus.req0_ok) && n < 40) begin
      @(negedge clk); #1; n++;
    end
    chk({nm, "_lat"}, 32'(n), 32'(lat));
    chk({nm, "_rom_cs_low"}, 32'(bus.rom_cs), 32'd0);
    chk({nm, "_rom_access"}, 32'(n_iss - i0), 32'(nrom));
    if (nrom > 0 && iss_q.size() > 0) chk({nm, "_issued_addr"}, 32'(iss_q[$]), 32'(a));
    @(negedge clk);
    if (id) bus.req1_cs = 1'b0; else bus.req0_cs = 1'b0;
  endtask

  task automatic wait_both(input int bound, output int n);
    n = 0;
    while (!(bus.req0_ok && bus.req1_ok) && n < bound) begin
      @(negedge clk); #1; n++;
    end
  endtask

  vec_t vt[10];
  int   n, i0;

  initial begin
    vt[0] = '{1'b0, 18'h00123, 3, 1'b0, 5, 1};
    vt[1] = '{1'b1, 18'h0ABCD, 1, 1'b0, 3, 1};
    vt[2] = '{1'b1, 18'h0ABCD, 1, 1'b0, 0, 0};
    vt[3] = '{1'b0, 18'h00123, 1, 1'b0, 0, 0};
    vt[4] = '{1'b1, 18'h3FFFF, 2, 1'b0, 4, 1};
    vt[5] = '{1'b0, 18'h00000, 1, 1'b0, 3, 1};
    vt[6] = '{1'b0, 18'h00001, 1, 1'b1, 3, 1};
    vt[7] = '{1'b0, 18'h00002, 1, 1'b1, 3, 1};
    vt[8] = '{1'b1, 18'h12345, 1, 1'b1, 3, 1};
    vt[9] = '{1'b1, 18'h12345, 1, 1'b1, 0, 0};

    bus.req0_cs = 1'b0; bus.req0_addr = '0;
    bus.req1_cs = 1'b0; bus.req1_addr = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rst_req0_ok", 32'(bus.req0_ok), 32'd0);
    chk("rst_req1_ok", 32'(bus.req1_ok), 32'd0);
    chk("rst_rom_cs", 32'(bus.rom_cs), 32'd0);
    chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    chk("rst_req0_data", 32'(bus.req0_data), 32'd0);
    chk("rst_req1_data", 32'(bus.req1_data), 32'd0);

    for (int i = 0; i < 10; i++) begin
      rom_dly = vt[i].dly;
      rom_stale = vt[i].stale;
      do_req(vt[i].id, vt[i].addr, vt[i].lat, vt[i].nrom, $sformatf("vec%0d", i));
    end
    rom_stale = 1'b0;

    // Contention: tie after reset goes to 0, then after a lone req0 the tie goes to 1
    rom_dly = 2;
    @(negedge clk);
    iss_q.delete();
    sb_push(1'b0, 18'h00100); sb_push(1'b1, 18'h00200);
    bus.req0_addr = 18'h00100; bus.req1_addr = 18'h00200;
    bus.req0_cs = 1'b1; bus.req1_cs = 1'b1;
    #1; wait_both(60, n);
    chk("pair1_lat", 32'(n), 32'd8);
    chk("pair1_issues", 32'(iss_q.size()), 32'd2);
    if (iss_q.size() == 2) begin
      chk("pair1_first", 32'(iss_q[0]), 32'h00100);
      chk("pair1_second", 32'(iss_q[1]), 32'h00200);
    end
    @(negedge clk); bus.req0_cs = 1'b0; bus.req1_cs = 1'b0;
    do_req(1'b0, 18'h00150, 4, 1, "single0");
    iss_q.delete();
    @(negedge clk);
    sb_push(1'b1, 18'h00400); sb_push(1'b0, 18'h00300);
    bus.req0_addr = 18'h00300; bus.req1_addr = 18'h00400;
    bus.req0_cs = 1'b1; bus.req1_cs = 1'b1;
    #1; wait_both(60, n);
    chk("pair2_lat", 32'(n), 32'd8);
    chk("pair2_issues", 32'(iss_q.size()), 32'd2);
    if (iss_q.size() == 2) begin
      chk("pair2_first", 32'(iss_q[0]), 32'h00400);
      chk("pair2_second", 32'(iss_q[1]), 32'h00300);
    end
    @(negedge clk); bus.req0_cs = 1'b0; bus.req1_cs = 1'b0;

    // Abort attempt: req0 leaves during WAIT, req1 arrives meanwhile
    rom_dly = 4;
    @(negedge clk);
    i0 = n_iss; iss_q.delete();
    bus.req0_addr = 18'h05555; bus.req0_cs = 1'b1;
    repeat (2) @(negedge clk);
    bus.req0_cs = 1'b0; bus.req0_addr = 18'h07777;
    sb_push(1'b1, 18'h06666);
    bus.req1_addr = 18'h06666; bus.req1_cs = 1'b1;
    #1;
    chk("abort_rom_cs_held", 32'(bus.rom_cs), 32'd1);
    n = 0;
    while (!bus.req1_ok && n < 60) begin @(negedge clk); #1; n++; end
    chk("abort_req1_done", 32'(bus.req1_ok), 32'd1);
    chk("abort_issues", 32'(iss_q.size()), 32'd2);
    if (iss_q.size() == 2) begin
      chk("abort_first", 32'(iss_q[0]), 32'h05555);
      chk("abort_second", 32'(iss_q[1]), 32'h06666);
    end
    @(negedge clk);
    sb_push(1'b0, 18'h05555);
    bus.req0_addr = 18'h05555; bus.req0_cs = 1'b1;
    #1;
    chk("abort_slot0_hit", 32'(bus.req0_ok), 32'd1);
    chk("abort_rom_count", 32'(n_iss - i0), 32'd2);

    // Async reset in WAIT: everything drops at once, both requests refetched
    rom_dly = 6;
    @(negedge clk);
    i0 = n_iss;
    sb_push(1'b0, 18'h01111);
    bus.req0_addr = 18'h01111;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rom_cs", 32'(bus.rom_cs), 32'd0);
    chk("arst_rom_addr", 32'(bus.rom_addr), 32'd0);
    chk("arst_req0_ok", 32'(bus.req0_ok), 32'd0);
    chk("arst_req1_ok", 32'(bus.req1_ok), 32'd0);
    sb_push(1'b1, 18'h06666);
    #1 rst_n = 1'b1;
    wait_both(80, n);
    chk("arst_both_done", 32'(bus.req0_ok & bus.req1_ok), 32'd1);
    chk("arst_rom_count", 32'(n_iss - i0), 32'd3);

    @(negedge clk); bus.req0_cs = 1'b0; bus.req1_cs = 1'b0;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
